// File: rtl/cookie_pkg.sv
// -----------------------------------------------------------------------------
// cookie_pkg
// Shared constants and types for the cookie controller slice.
//   TS_WIDTH   : width of the free-running time stamp handed to the generator
//   COOKIE_LEN : width of one cookie
//   EPOCH_W    : width of the wrapping rotation counter
//   state_e    : rotation sequencer states
// -----------------------------------------------------------------------------
package cookie_pkg;

    localparam int TS_WIDTH   = 96;
    localparam int COOKIE_LEN = 32;
    localparam int EPOCH_W    = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        COMMIT = 2'd3
    } state_e;

endpackage : cookie_pkg

// File: rtl/cookie_ctrl_if.sv
// -----------------------------------------------------------------------------
// cookie_ctrl_if
// Validation request/response bundle between the requester lanes and
// cookie_ctrl.
//   req_valid  : per-lane check request
//   req_cookie : lane i cookie at [i*COOKIE_LEN +: COOKIE_LEN]
//   req_ready  : one-hot grant (combinational in the controller)
//   rsp_valid  : one-hot, registered, one cycle after the grant
//   rsp_match  : result for the lane flagged by rsp_valid
// Modports: master = requester side, slave = cookie_ctrl side.
// -----------------------------------------------------------------------------
interface cookie_ctrl_if
    import cookie_pkg::*;
#(
    parameter int NUM_REQ = 4
);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*COOKIE_LEN-1:0] req_cookie;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic                          rsp_match;

    modport master (
        output req_valid,
        output req_cookie,
        input  req_ready,
        input  rsp_valid,
        input  rsp_match
    );

    modport slave (
        input  req_valid,
        input  req_cookie,
        output req_ready,
        output rsp_valid,
        output rsp_match
    );

endinterface : cookie_ctrl_if

// File: rtl/cookie_rr_arb.sv
// -----------------------------------------------------------------------------
// cookie_rr_arb
// Round-robin arbiter for the validation lanes. The lowest requesting index at
// or above the pointer wins; the pointer then moves just past the winner and
// holds when nobody requests.
//   clk, rst_n : clock, asynchronous active-low reset
//   req_valid  : per-lane requests
//   grant      : one-hot grant, combinational
//   grant_idx  : index of the granted lane (0 when no grant)
// -----------------------------------------------------------------------------
module cookie_rr_arb #(
    parameter int NUM_REQ = 4,
    localparam int IW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      grant_idx
);

    logic [IW-1:0] ptr;
    logic          found;
    int unsigned   cand;

    // NOTE: every variable written here gets a default before the loop, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (int'(ptr) + i) % NUM_REQ;
            if (!found && req_valid[cand]) begin
                found           = 1'b1;
                grant[cand]     = 1'b1;
                grant_idx       = IW'(cand);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule : cookie_rr_arb

// File: rtl/cookie_ctrl.sv
// -----------------------------------------------------------------------------
// cookie_ctrl
// Sequences the external cookie generator and validates received cookies.
//   clk, rst_n   : clock, asynchronous active-low reset
//   rotate_now   : single-cycle request for an immediate rotation
//   gen_ts       : time stamp latched for the generator, held between launches
//   gen_val      : generator result, stable COOKIE_LAT cycles after gen_ts
//   cur_cookie   : active cookie for stamping outgoing control packets
//   cookie_valid : cur_cookie is usable
//   epoch        : rotation count, wraps
//   bus          : validation lanes (slave side of cookie_ctrl_if)
// -----------------------------------------------------------------------------
module cookie_ctrl
    import cookie_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int ROTATE_PERIOD = 1024,
    parameter int COOKIE_LAT    = 2,
    localparam int IW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int PW           = (ROTATE_PERIOD > 1) ? $clog2(ROTATE_PERIOD) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rotate_now,
    output logic [TS_WIDTH-1:0]   gen_ts,
    input  logic [COOKIE_LEN-1:0] gen_val,
    output logic [COOKIE_LEN-1:0] cur_cookie,
    output logic                  cookie_valid,
    output logic [EPOCH_W-1:0]    epoch,
    cookie_ctrl_if.slave          bus
);

    state_e                  state;
    logic                    boot;
    logic                    pending;
    logic [PW-1:0]           period_cnt;
    logic [2:0]              wait_cnt;
    logic [TS_WIDTH-1:0]     ts_cnt;
    logic [COOKIE_LEN-1:0]   cur;
    logic [COOKIE_LEN-1:0]   prev;
    logic                    cur_valid;
    logic                    prev_valid;

    logic [NUM_REQ-1:0]      grant;
    logic [IW-1:0]           grant_idx;
    logic [COOKIE_LEN-1:0]   sel_cookie;
    logic                    hit;
    logic [NUM_REQ-1:0]      rsp_valid_q;
    logic                    rsp_match_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_cnt <= '0;
        end else begin
            ts_cnt <= ts_cnt + TS_WIDTH'(1);
        end
    end

    // Launch side effects are registered on the edge that leaves IDLE, so
    // gen_ts carries the time stamp of the cycle that decided to rotate and is
    // already stable during the LAUNCH cycle. Commit happens on the edge that
    // leaves COMMIT, after gen_val has had COOKIE_LAT cycles to settle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            boot       <= 1'b1;
            pending    <= 1'b0;
            period_cnt <= '0;
            wait_cnt   <= '0;
            gen_ts     <= '0;
            cur        <= '0;
            prev       <= '0;
            cur_valid  <= 1'b0;
            prev_valid <= 1'b0;
            epoch      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    period_cnt <= period_cnt + 1'b1;
                    if (boot || rotate_now || pending ||
                        period_cnt == PW'(ROTATE_PERIOD - 1)) begin
                        state      <= LAUNCH;
                        gen_ts     <= ts_cnt;
                        period_cnt <= '0;
                        boot       <= 1'b0;
                        pending    <= 1'b0;
                        wait_cnt   <= '0;
                    end
                end
                LAUNCH: begin
                    state <= WAIT;
                    if (rotate_now) pending <= 1'b1;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (wait_cnt == 3'(COOKIE_LAT)) state <= COMMIT;
                    if (rotate_now) pending <= 1'b1;
                end
                COMMIT: begin
                    prev       <= cur;
                    prev_valid <= cur_valid;
                    cur        <= gen_val;
                    cur_valid  <= 1'b1;
                    epoch      <= epoch + 1'b1;
                    state      <= IDLE;
                    if (rotate_now) pending <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    cookie_rr_arb #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (bus.req_valid),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // The compare reads cur/prev as they stand at the grant edge, so a grant in
    // the COMMIT cycle is judged against the pre-commit pair.
    always_comb begin
        sel_cookie = bus.req_cookie[int'(grant_idx)*COOKIE_LEN +: COOKIE_LEN];
        hit        = ((sel_cookie == cur)  && cur_valid) ||
                     ((sel_cookie == prev) && prev_valid);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= '0;
            rsp_match_q <= 1'b0;
        end else begin
            rsp_valid_q <= grant;
            rsp_match_q <= (|grant) && hit;
        end
    end

    assign bus.req_ready = grant;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_match = rsp_match_q;
    assign cur_cookie    = cur;
    assign cookie_valid  = cur_valid;

endmodule : cookie_ctrl

// File: tb/tb_cookie_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cookie_ctrl
// Directed bench for cookie_ctrl with ROTATE_PERIOD=16, COOKIE_LAT=2,
// NUM_REQ=4. The generator model is gen_ts[31:0]^A5A5A5A5 delayed 2 cycles.
// Cycle n means 1 time unit after the n-th rising edge following rst_n release.
// A launch decided at edge L latches ts_cnt = L-1 and commits at edge L+5;
// periodic launches come 16 edges after the previous commit.
// -----------------------------------------------------------------------------
module tb_cookie_ctrl;
    import cookie_pkg::*;

    localparam int NUM_REQ = 4;
    localparam logic [31:0] K = 32'hA5A5A5A5;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  rotate_now = 1'b0;
    logic [TS_WIDTH-1:0]   gen_ts;
    logic [COOKIE_LEN-1:0] gen_val = '0;
    logic [COOKIE_LEN-1:0] gen_pipe = '0;
    logic [COOKIE_LEN-1:0] cur_cookie;
    logic                  cookie_valid;
    logic [EPOCH_W-1:0]    epoch;

    int n_total = 0;
    int n_pass  = 0;
    int cyc;

    cookie_ctrl_if #(.NUM_REQ(NUM_REQ)) bus ();

    cookie_ctrl #(
        .NUM_REQ       (NUM_REQ),
        .ROTATE_PERIOD (16),
        .COOKIE_LAT    (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rotate_now   (rotate_now),
        .gen_ts       (gen_ts),
        .gen_val      (gen_val),
        .cur_cookie   (cur_cookie),
        .cookie_valid (cookie_valid),
        .epoch        (epoch),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        gen_pipe <= gen_ts[31:0] ^ K;
        gen_val  <= gen_pipe;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic at_cyc(input int n);
        int guard = 0;
        while (cyc < n && guard < 500) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (cyc != n) check("sync", 96'(cyc), 96'(n));
    endtask

    task automatic put(input int lane, input logic [31:0] c);
        bus.req_valid = '0;
        bus.req_valid[lane] = 1'b1;
        bus.req_cookie[lane*32 +: 32] = c;
        #1;
    endtask

    task automatic idle_req();
        bus.req_valid = '0;
    endtask

    initial begin
        bus.req_valid  = '0;
        bus.req_cookie = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 96'(cookie_valid), 96'(0));
        check("rst_epoch", 96'(epoch), 96'(0));
        check("rst_cur", 96'(cur_cookie), 96'(0));
        check("rst_gen_ts", gen_ts, 96'(0));
        check("rst_rsp_valid", 96'(bus.rsp_valid), 96'(0));
        check("rst_rsp_match", 96'(bus.rsp_match), 96'(0));
        check("rst_ready", 96'(bus.req_ready), 96'(0));

        // Boot with all lanes requesting: RR order 0,1,2,3,0; no cookie valid yet.
        @(negedge clk);
        rst_n = 1'b1;
        bus.req_valid  = 4'hF;
        bus.req_cookie = {4{K}};
        #1;
        check("arb_ready0", 96'(bus.req_ready), 96'(4'b0001));
        for (int k = 1; k <= 5; k++) begin
            at_cyc(k);
            check("arb_rsp_valid", 96'(bus.rsp_valid), 96'(4'b0001 << ((k - 1) % 4)));
            check("boot_match", 96'(bus.rsp_match), 96'(0));
            check("arb_ready", 96'(bus.req_ready), 96'(4'b0001 << (k % 4)));
            if (k == 1) check("boot_gen_ts", gen_ts, 96'(0));
        end
        check("boot_valid_c5", 96'(cookie_valid), 96'(0));
        idle_req();

        at_cyc(6);
        check("idle_rsp_valid", 96'(bus.rsp_valid), 96'(0));
        check("idle_rsp_match", 96'(bus.rsp_match), 96'(0));
        check("boot_valid", 96'(cookie_valid), 96'(1));
        check("boot_epoch", 96'(epoch), 96'(1));
        check("boot_cur", 96'(cur_cookie), 96'(K));

        // Periodic rotation: launch at edge 22 latches ts 21 (0x15).
        at_cyc(26);
        check("rot2_early", 96'(epoch), 96'(1));
        at_cyc(27);
        check("rot2_epoch", 96'(epoch), 96'(2));
        check("rot2_cur", 96'(cur_cookie), 96'(32'hA5A5A5B0));
        put(2, K);
        check("prev_ready", 96'(bus.req_ready), 96'(4'b0100));
        at_cyc(28);
        check("prev_rsp_valid", 96'(bus.rsp_valid), 96'(4'b0100));
        check("prev_match", 96'(bus.rsp_match), 96'(1));
        put(3, 32'h12345678);
        at_cyc(29);
        check("bad_rsp_valid", 96'(bus.rsp_valid), 96'(4'b1000));
        check("bad_match", 96'(bus.rsp_match), 96'(0));
        idle_req();

        // Third rotation (ts 42 = 0x2A). A grant in the COMMIT cycle still sees
        // A5A5A5A5 as prev.
        at_cyc(47);
        put(0, K);
        at_cyc(48);
        check("rot3_epoch", 96'(epoch), 96'(3));
        check("rot3_cur", 96'(cur_cookie), 96'(32'hA5A5A58F));
        check("commit_edge_match", 96'(bus.rsp_match), 96'(1));
        put(1, K);
        at_cyc(49);
        check("stale_match", 96'(bus.rsp_match), 96'(0));
        put(2, 32'hA5A5A5B0);
        at_cyc(50);
        check("epoch2_rsp_valid", 96'(bus.rsp_valid), 96'(4'b0100));
        check("epoch2_match", 96'(bus.rsp_match), 96'(1));
        idle_req();

        // Periodic launch at 64 (ts 0x3F); pulses in LAUNCH, WAIT and COMMIT
        // collapse into a single extra launch at 70 (ts 0x45).
        at_cyc(64); rotate_now = 1'b1;
        at_cyc(65); rotate_now = 1'b0;
        at_cyc(66); rotate_now = 1'b1;
        at_cyc(67); rotate_now = 1'b0;
        at_cyc(68); rotate_now = 1'b1;
        at_cyc(69); rotate_now = 1'b0;
        check("rot4_epoch", 96'(epoch), 96'(4));
        check("rot4_cur", 96'(cur_cookie), 96'(32'hA5A5A59A));
        at_cyc(74);
        check("pend_early", 96'(epoch), 96'(4));
        at_cyc(75);
        check("pend_epoch", 96'(epoch), 96'(5));
        check("pend_cur", 96'(cur_cookie), 96'(32'hA5A5A5E0));
        at_cyc(90);
        check("pend_once", 96'(epoch), 96'(5));

        // Reset in WAIT of the launch decided at edge 91.
        at_cyc(93);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 96'(cookie_valid), 96'(0));
        check("midrst_epoch", 96'(epoch), 96'(0));
        check("midrst_cur", 96'(cur_cookie), 96'(0));
        @(negedge clk);
        rst_n = 1'b1;
        put(0, 32'hA5A5A5E0);
        at_cyc(1);
        check("reboot_rsp_valid", 96'(bus.rsp_valid), 96'(4'b0001));
        check("reboot_old_match", 96'(bus.rsp_match), 96'(0));
        put(1, K);
        at_cyc(2);
        check("reboot_early_match", 96'(bus.rsp_match), 96'(0));
        idle_req();
        at_cyc(5);
        check("reboot_valid_c5", 96'(cookie_valid), 96'(0));
        at_cyc(6);
        check("reboot_valid", 96'(cookie_valid), 96'(1));
        check("reboot_epoch", 96'(epoch), 96'(1));
        check("reboot_cur", 96'(cur_cookie), 96'(K));
        put(2, K);
        at_cyc(7);
        check("reboot_match", 96'(bus.rsp_match), 96'(1));
        idle_req();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_cookie_ctrl
